// File: rtl/axis_bit_packer_pkg.sv
// Shared helpers for the bit packer: sizing functions and the parameter legality check.
package axis_bit_packer_pkg;

   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

   function automatic int unsigned lanes(input int unsigned word_w, input int unsigned in_w);
      return word_w / in_w;
   endfunction

   function automatic bit params_ok(input int unsigned word_w, input int unsigned in_w,
                                    input int unsigned depth);
      return (in_w != 0) && (word_w % in_w == 0) && (depth >= 2) &&
             ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/axis_bit_packer_if.sv
// Sample-side handshake plus AXI4-Stream master bus of the packer, with fill level.
interface axis_bit_packer_if #(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned IN_WIDTH             = 1,
   parameter int unsigned FIFO_DEPTH           = 4
);
   import axis_bit_packer_pkg::*;

   localparam int unsigned LvlW = clogb2(FIFO_DEPTH) + 1;

   logic                            in_valid;
   logic [IN_WIDTH-1:0]             in_data;
   logic                            layer_finish;
   logic                            in_ready;
   logic                            m_axis_tvalid;
   logic                            m_axis_tready;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
   logic                            m_axis_tlast;
   logic [LvlW-1:0]                 fifo_level;

   // The packer itself.
   modport master (
      input  in_valid, in_data, layer_finish, m_axis_tready,
      output in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level
   );

   // Surrounding producer/consumer.
   modport slave (
      output in_valid, in_data, layer_finish, m_axis_tready,
      input  in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level
   );

endinterface

// File: rtl/axis_pack_fifo.sv
// Synchronous FIFO with a registered head entry and an occupancy count.
module axis_pack_fifo
   import axis_bit_packer_pkg::*;
#(
   parameter int unsigned Width = 33,
   parameter int unsigned Depth = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push_i,
   input  logic [Width-1:0]            wdata_i,
   input  logic                        pop_i,
   output logic [Width-1:0]            rdata_o,
   output logic                        valid_o,
   output logic [clogb2(Depth):0]      count_o
);
   localparam int unsigned AW   = clogb2(Depth);
   localparam int unsigned LvlW = AW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_q, rd_q, rd_next;
   logic [LvlW-1:0]  cnt_q, cnt_d;
   logic [Width-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign valid_o = (cnt_q != '0);
   assign do_pop  = pop_i && valid_o;
   assign do_push = push_i && (cnt_q != LvlW'(Depth));
   assign rd_next = rd_q + AW'(1);

   // Head is loaded on the edge that makes an entry the oldest, so the output only moves on edges.
   always_comb begin
      head_d = head_q;
      cnt_d  = cnt_q;
      if (cnt_q == '0) begin
         if (do_push) head_d = wdata_i;
      end else if (do_pop) begin
         if (cnt_q > LvlW'(1)) head_d = mem_q[rd_next];
         else if (do_push)     head_d = wdata_i;
      end
      if (do_push && !do_pop)      cnt_d = cnt_q + LvlW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - LvlW'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_next;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   assign rdata_o = head_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/axis_bit_packer.sv
// Packs IN_WIDTH-bit samples LSB-first into AXI4-Stream words; layer_finish flushes with tlast.
module axis_bit_packer
   import axis_bit_packer_pkg::*;
#(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned IN_WIDTH             = 1,
   parameter int unsigned FIFO_DEPTH           = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   axis_bit_packer_if.master bus
);
   localparam int unsigned DW    = C_M_AXIS_TDATA_WIDTH;
   localparam int unsigned Lanes = lanes(C_M_AXIS_TDATA_WIDTH, IN_WIDTH);
   localparam int unsigned PtrW  = (Lanes > 1) ? clogb2(Lanes) : 1;
   localparam int unsigned LvlW  = clogb2(FIFO_DEPTH) + 1;

   if (!params_ok(C_M_AXIS_TDATA_WIDTH, IN_WIDTH, FIFO_DEPTH)) begin : g_bad_params
      $error("axis_bit_packer: width must be a multiple of IN_WIDTH, depth a power of two >= 2");
   end

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [DW-1:0]   acc_q, acc_d, word;
   logic [LvlW-1:0] level;
   logic [DW:0]     head;
   logic            in_ready, accept_s, accept_f, lane_last, push;

   // Readiness comes from the registered count only, never from m_axis_tready.
   assign in_ready  = (level < LvlW'(FIFO_DEPTH));
   assign accept_s  = bus.in_valid && in_ready;
   assign accept_f  = bus.layer_finish && in_ready;
   assign lane_last = (ptr_q == PtrW'(Lanes - 1));
   assign push      = (accept_s && lane_last) || accept_f;

   always_comb begin
      // Lane 0 starts a fresh word so no bits of the previous word leak through.
      word = (ptr_q == '0) ? '0 : acc_q;
      if (accept_s) begin
         for (int unsigned l = 0; l < Lanes; l++) begin
            if (ptr_q == PtrW'(l)) word[l*IN_WIDTH +: IN_WIDTH] = bus.in_data;
         end
      end
      acc_d = acc_q;
      ptr_d = ptr_q;
      if (accept_s) begin
         acc_d = word;
         ptr_d = lane_last ? '0 : ptr_q + PtrW'(1);
      end
      if (accept_f) ptr_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         acc_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         acc_q <= acc_d;
      end
   end

   axis_pack_fifo #(
      .Width (DW + 1),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({accept_f, word}),
      .pop_i   (bus.m_axis_tready),
      .rdata_o (head),
      .valid_o (bus.m_axis_tvalid),
      .count_o (level)
   );

   assign bus.in_ready     = in_ready;
   assign bus.m_axis_tdata = head[DW-1:0];
   assign bus.m_axis_tlast = head[DW];
   assign bus.fifo_level   = level;

endmodule
